// File: rtl/conv_sched_ctrl.sv
// conv_sched_ctrl: output-channel / window sequencer for one conv layer.
// For each channel: load kernel, wait for weights, sweep windows.
//
// Ports:
//   clk, rst       clock (rising edge), async active-high reset
//   start          begin a layer (only sampled while idle)
//   abort          synchronous abort back to idle (ignored while idle)
//   mac_ready      MAC array accepts the current window
//   cout           output-channel index for the kernel loader
//   c_load         one-cycle kernel load strobe
//   acc_clr        one-cycle accumulator clear (with c_load)
//   win_valid      row/col window is valid
//   row, col       top-left corner of the current window
//   busy           high whenever not idle
//   done           one-cycle pulse when the whole layer is finished
//   stall_cnt      window stall cycles of the current/last layer
//
// Optional feature macro: CONV_SCHED_STALL_CNT_EN
//   defined   -> stall_cnt counts win_valid & !mac_ready cycles,
//                cleared at layer start, saturating at 16'hFFFF
//   undefined -> stall_cnt is tied to zero

module conv_sched_ctrl #(
    parameter int NUM_COUT  = 8,
    parameter int COUT_W    = 4,
    parameter int IMG_W     = 28,
    parameter int IMG_H     = 28,
    parameter int K         = 3,
    parameter int KLOAD_LAT = 2,
    parameter int POS_W     = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              mac_ready,
    output logic [COUT_W-1:0] cout,
    output logic              c_load,
    output logic              acc_clr,
    output logic              win_valid,
    output logic [POS_W-1:0]  row,
    output logic [POS_W-1:0]  col,
    output logic              busy,
    output logic              done,
    output logic [15:0]       stall_cnt
);

    localparam int OUT_W = IMG_W - K + 1;
    localparam int OUT_H = IMG_H - K + 1;
    localparam int SET_W = (KLOAD_LAT > 1) ? $clog2(KLOAD_LAT) : 1;

    localparam logic [SET_W-1:0]  SET_LAST  = SET_W'(KLOAD_LAT - 1);
    localparam logic [POS_W-1:0]  COL_LAST  = POS_W'(OUT_W - 1);
    localparam logic [POS_W-1:0]  ROW_LAST  = POS_W'(OUT_H - 1);
    localparam logic [COUT_W-1:0] COUT_LAST = COUT_W'(NUM_COUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SETTLE,
        SWEEP,
        DONE
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic [SET_W-1:0]   settle;
    logic [SET_W-1:0]   settle_nx;
    logic [COUT_W-1:0]  cout_nx;
    logic [POS_W-1:0]   row_nx;
    logic [POS_W-1:0]   col_nx;
    logic               c_load_nx;
    logic               win_valid_nx;
    logic               busy_nx;
    logic               done_nx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            settle    <= '0;
            cout      <= '0;
            row       <= '0;
            col       <= '0;
            c_load    <= 1'b0;
            acc_clr   <= 1'b0;
            win_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nx;
            settle    <= settle_nx;
            cout      <= cout_nx;
            row       <= row_nx;
            col       <= col_nx;
            c_load    <= c_load_nx;
            acc_clr   <= c_load_nx;
            win_valid <= win_valid_nx;
            busy      <= busy_nx;
            done      <= done_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        settle_nx = settle;
        cout_nx   = cout;
        row_nx    = row;
        col_nx    = col;

        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = LOAD;
                    cout_nx  = '0;
                end
            end
            LOAD: begin
                state_nx  = SETTLE;
                settle_nx = '0;
            end
            SETTLE: begin
                if (settle == SET_LAST) begin
                    state_nx = SWEEP;
                    row_nx   = '0;
                    col_nx   = '0;
                end else begin
                    settle_nx = settle + 1'b1;
                end
            end
            SWEEP: begin
                // In SWEEP win_valid is high, so mac_ready alone
                // decides whether the window transfers.
                if (mac_ready) begin
                    if (col == COL_LAST) begin
                        col_nx = '0;
                        if (row == ROW_LAST) begin
                            row_nx = '0;
                            if (cout == COUT_LAST) begin
                                state_nx = DONE;
                            end else begin
                                cout_nx  = cout + 1'b1;
                                state_nx = LOAD;
                            end
                        end else begin
                            row_nx = row + 1'b1;
                        end
                    end else begin
                        col_nx = col + 1'b1;
                    end
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        if (abort && state != IDLE) begin
            state_nx  = IDLE;
            settle_nx = '0;
            row_nx    = '0;
            col_nx    = '0;
        end

        // Outputs are registered decodes of the next state.
        c_load_nx    = (state_nx == LOAD);
        win_valid_nx = (state_nx == SWEEP);
        busy_nx      = (state_nx != IDLE);
        done_nx      = (state_nx == DONE);
    end

`ifdef CONV_SCHED_STALL_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else if (state == IDLE && start) begin
            stall_q <= '0;
        end else if (win_valid && !mac_ready
                     && stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = 16'd0;
`endif

endmodule

// File: doc/conv_sched_ctrl.md
Name: conv_sched_ctrl

Overview:
Sequencer for one convolution layer.
- Steps the output-channel index `cout` through all channels.
- Pulses `c_load` so the kernel loader presents that channel's 3x3 weights on kernel0..kernel8.
- Waits a fixed settle time for the weights.
- Sweeps every valid output-pixel position, presenting (row, col) window strobes to the MAC array under a ready handshake.
- Sits between the layer-level start/done control and the kernel-loader + MAC datapath.

Parameters:
NUM_COUT, 8, number of output channels (1..16).
COUT_W, 4, width of cout.
IMG_W, 28, input feature-map width.
IMG_H, 28, input feature-map height.
K, 3, kernel size; OUT_W = IMG_W-K+1, OUT_H = IMG_H-K+1.
KLOAD_LAT, 2, cycles from c_load pulse until kernel outputs are valid (>=1).
POS_W, 5, width of row/col outputs.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous reset, active-high.
start  in  1  begin layer; sampled only in IDLE.
abort  in  1  synchronous abort; returns to IDLE.
mac_ready  in  1  MAC array accepts current window.
cout  out  COUT_W  current output-channel index to kernel loader.
c_load  out  1  one-cycle kernel load strobe.
acc_clr  out  1  one-cycle accumulator clear, coincident with c_load.
win_valid  out  1  row/col window valid.
row  out  POS_W  top-left row of current window.
col  out  POS_W  top-left column of current window.
busy  out  1  high in any state except IDLE.
done  out  1  one-cycle pulse after last window of last channel accepted.
stall_cnt  out  16  stall counter (see Optional Feature).

Behaviour:
- All outputs registered. While rst=1, all outputs are 0, state=IDLE, counters=0.
- rst takes effect immediately and asynchronously, including mid-sweep. No done pulse is produced for an interrupted layer.
- FSM states: IDLE, LOAD, SETTLE, SWEEP, DONE.
- IDLE:
  - busy=0.
  - start=1 at an edge -> LOAD, cout<=0.
  - cout otherwise holds its last value.
- LOAD (1 cycle):
  - c_load=1, acc_clr=1, cout stable.
  - Next state SETTLE, settle counter<=0.
- SETTLE:
  - Lasts exactly KLOAD_LAT cycles; c_load=0.
  - Then SWEEP with row=0, col=0.
- SWEEP:
  - win_valid=1; row/col held stable until accepted.
  - Transfer occurs on an edge where win_valid & mac_ready.
  - On transfer: col<=col+1. If col==OUT_W-1: col<=0, row<=row+1.
  - On transfer of (OUT_H-1, OUT_W-1):
    - if cout==NUM_COUT-1 -> DONE;
    - else cout<=cout+1 -> LOAD; row and col are reset to 0.
  - win_valid drops in the cycle after the final transfer.
- DONE (1 cycle): done=1, busy=1, then IDLE.
- abort=1 in any non-IDLE state (highest priority after rst):
  - next cycle is IDLE; win_valid, c_load, acc_clr, busy = 0; no done pulse.
  - abort in IDLE is ignored.
  - abort and start together in IDLE: start wins.
- start while busy is ignored and is not queued.
- Latency with no stalls: start edge to done high = NUM_COUT*(1+KLOAD_LAT+OUT_W*OUT_H) cycles. done is high during the following cycle.
- Each mac_ready=0 cycle during SWEEP adds exactly one cycle to the latency.
- cout never exceeds NUM_COUT-1. row/col never exceed OUT_H-1 / OUT_W-1.

Optional Feature:
CONV_SCHED_STALL_CNT_EN.
- Defined:
  - stall_cnt counts cycles with win_valid=1 & mac_ready=0.
  - Cleared to 0 on the LOAD entry from IDLE (the start of a layer).
  - Saturates at 16'hFFFF; holds its value after done until the next start.
- Not defined: stall_cnt is constant 0 and no counter logic is synthesised.

Test Plan:
1. Params IMG_W=IMG_H=5, K=3, NUM_COUT=2, KLOAD_LAT=2, mac_ready=1.
   - Pulse start -> c_load high for 1 cycle with cout=0.
   - win_valid rises 3 cycles after c_load, then 9 windows (0,0)..(2,2) in row-major order.
   - c_load again with cout=1.
   - done pulses exactly 24 cycles after the start edge.
2. Same params, mac_ready low for 3 cycles at window (1,1) -> row/col hold (1,1) during the stall; done delayed by exactly 3 cycles; stall_cnt=3 when the macro is defined.
3. Assert rst mid-SWEEP at cout=1 -> all outputs 0 immediately, before the next clock edge. A fresh start then restarts at cout=0, row=0, col=0.
4. abort during SETTLE of channel 0 -> IDLE next cycle, no done pulse. A start in the same cycle as abort is ignored.
5. start asserted again during SWEEP -> ignored. done pulses once. A start two cycles after done runs a full second layer.
6. NUM_COUT=1, K=IMG_W=IMG_H=3 (single window) -> c_load, 2 settle cycles, one win_valid transfer at (0,0), done; total latency 4 cycles.
